// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream, memory-write and status signals of program_loader.
interface program_loader_if;
   logic        start;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        mem_we;
   logic        cpu_run;
   logic        busy;
   logic        error;
   logic [15:0] words_loaded;
   modport master (
      output start, byte_in, byte_valid,
      input  byte_ready, mem_addr, mem_data, mem_we, cpu_run, busy, error, words_loaded
   );
   modport slave (
      input  start, byte_in, byte_valid,
      output byte_ready, mem_addr, mem_data, mem_we, cpu_run, busy, error, words_loaded
   );
endinterface

// File: rtl/program_loader.sv
// program_loader: loads a length-prefixed little-endian byte stream into word memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum word before DONE.
module program_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 1024
) (
   input logic             clk,
   input logic             rst_n,
   program_loader_if.slave bus
);
`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CSUM, DONE, ERROR} state_t;
   localparam state_t FIN = CSUM;
   logic [31:0] r_csum;
`else
   typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERROR} state_t;
   localparam state_t FIN = DONE;
`endif
   state_t      r_state;
   logic [1:0]  r_idx;
   logic [23:0] r_word;
   logic [31:0] r_len;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_data;
   logic [15:0] r_words;
   logic        w_hs;
   logic        w_last;
   logic [31:0] w_word;
   logic [15:0] w_words_inc;
   assign w_hs        = bus.byte_valid && bus.byte_ready;
   assign w_last      = r_idx == 2'd3;
   assign w_word      = {bus.byte_in, r_word};
   assign w_words_inc = r_words + 16'd1;
`ifdef LOADER_CHECKSUM_EN
   assign bus.byte_ready = r_state inside {LEN, DATA, CSUM};
   assign bus.busy       = r_state inside {LEN, DATA, WRITE, CSUM};
`else
   assign bus.byte_ready = r_state inside {LEN, DATA};
   assign bus.busy       = r_state inside {LEN, DATA, WRITE};
`endif
   assign bus.mem_we       = r_state == WRITE;
   assign bus.cpu_run      = r_state == DONE;
   assign bus.error        = r_state == ERROR;
   assign bus.mem_addr     = r_mem_addr;
   assign bus.mem_data     = r_mem_data;
   assign bus.words_loaded = r_words;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_idx      <= 2'd0;
         r_word     <= 24'd0;
         r_len      <= 32'd0;
         r_mem_addr <= 32'd0;
         r_mem_data <= 32'd0;
         r_words    <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
         r_csum     <= 32'd0;
`endif
      end else begin
         // bytes shift in from the top so the first one ends up in bits 7:0
         if (w_hs) begin
            r_word <= {bus.byte_in, r_word[23:8]};
            r_idx  <= r_idx + 2'd1;
         end
         case (r_state)
            IDLE, DONE, ERROR: if (bus.start) begin
               r_state <= LEN;
               r_idx   <= 2'd0;
               r_words <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
               r_csum  <= 32'd0;
`endif
            end
            LEN: if (w_hs && w_last) begin
               r_len   <= w_word;
               r_state <= w_word == 32'd0 ? FIN : (w_word > 32'(MAX_WORDS) ? ERROR : DATA);
            end
            DATA: if (w_hs && w_last) begin
               r_mem_data <= w_word;
               r_mem_addr <= BASE_ADDR + {14'd0, r_words, 2'b00};
               r_state    <= WRITE;
            end
            WRITE: begin
               r_words <= w_words_inc;
               r_state <= {16'd0, w_words_inc} == r_len ? FIN : DATA;
`ifdef LOADER_CHECKSUM_EN
               r_csum  <= r_csum ^ r_mem_data;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: if (w_hs && w_last) r_state <= w_word == r_csum ? DONE : ERROR;
`endif
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized loads against a queue-based model of expected memory writes and final status.
module tb_program_loader;
   localparam int          MAXW = 1024;
   localparam logic [31:0] BASE = 32'h0000_0000;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] exp_q[$];
   logic [31:0] dir_w[$];
   logic [63:0] mon_e;
   logic        noisy = 1'b0;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0] csum_flip = 32'd0;
`endif
   program_loader_if bus();
   program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // every write the DUT issues must be the next one the model predicts
   always @(negedge clk) if (bus.mem_we === 1'b1) begin
      check("we_ready_low", {31'd0, bus.byte_ready}, 32'd0);
      if (exp_q.size() == 0) check("unexpected_we", 32'd1, 32'd0);
      else begin
         mon_e = exp_q.pop_front();
         check("we_addr", bus.mem_addr, mon_e[63:32]);
         check("we_data", bus.mem_data, mon_e[31:0]);
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic send_byte(input logic [7:0] b, input int g);
      int gap;
      int t;
      gap = g < 0 ? int'($urandom_range(0, 2)) : g;
      t = 0;
      bus.byte_valid = 1'b0;
      bus.start = 1'b0;
      repeat (gap) step();
      bus.byte_in = b;
      bus.byte_valid = 1'b1;
      bus.start = noisy;
      while (!bus.byte_ready && t < 20) begin
         step();
         t++;
      end
      if (t == 20) check("ready_timeout", 32'd0, 32'd1);
      step();
      bus.byte_valid = 1'b0;
      bus.start = 1'b0;
   endtask
   task automatic send_word(input logic [31:0] w, input int g, input bit data);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], g);
      if (data) check("we_latency", {31'd0, bus.mem_we}, 32'd1);
   endtask
   task automatic chk_reset(input string tag);
      check({tag, "_ready"}, {31'd0, bus.byte_ready}, 32'd0);
      check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      check({tag, "_run"}, {31'd0, bus.cpu_run}, 32'd0);
      check({tag, "_err"}, {31'd0, bus.error}, 32'd0);
      check({tag, "_we"}, {31'd0, bus.mem_we}, 32'd0);
      check({tag, "_addr"}, bus.mem_addr, 32'd0);
      check({tag, "_data"}, bus.mem_data, 32'd0);
      check({tag, "_words"}, {16'd0, bus.words_loaded}, 32'd0);
   endtask
   task automatic load(input logic [31:0] n, input int g, input string tag);
      logic [31:0] w;
      logic [31:0] x;
      logic        exp_err;
      int          t;
      x = 32'd0;
      exp_err = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check({tag, "_start_busy"}, {31'd0, bus.busy}, 32'd1);
      check({tag, "_start_err"}, {31'd0, bus.error}, 32'd0);
      check({tag, "_start_ready"}, {31'd0, bus.byte_ready}, 32'd1);
      check({tag, "_start_words"}, {16'd0, bus.words_loaded}, 32'd0);
      send_word(n, g, 1'b0);
      if (n > MAXW) begin
         check({tag, "_toolong_err"}, {31'd0, bus.error}, 32'd1);
         check({tag, "_toolong_ready"}, {31'd0, bus.byte_ready}, 32'd0);
         check({tag, "_toolong_busy"}, {31'd0, bus.busy}, 32'd0);
         check({tag, "_toolong_run"}, {31'd0, bus.cpu_run}, 32'd0);
         return;
      end
`ifndef LOADER_CHECKSUM_EN
      if (n == 0) check({tag, "_len0_next"}, {31'd0, bus.cpu_run}, 32'd1);
`endif
      for (int i = 0; i < int'(n); i++) begin
         w = i < dir_w.size() ? dir_w[i] : $urandom;
         exp_q.push_back({BASE + 32'(4 * i), w});
         x ^= w;
         send_word(w, g, 1'b1);
      end
`ifdef LOADER_CHECKSUM_EN
      send_word(x ^ csum_flip, g, 1'b0);
      exp_err = csum_flip != 32'd0;
`else
      x = x + 32'd0;
`endif
      t = 0;
      while (!bus.cpu_run && !bus.error && t < 10) begin
         step();
         t++;
      end
      check({tag, "_run"}, {31'd0, bus.cpu_run}, {31'd0, !exp_err});
      check({tag, "_err"}, {31'd0, bus.error}, {31'd0, exp_err});
      check({tag, "_words"}, {16'd0, bus.words_loaded}, {16'd0, n[15:0]});
      check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      check({tag, "_pending"}, exp_q.size(), 32'd0);
      dir_w.delete();
   endtask
   initial begin
      logic [31:0] w;
      bus.start = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_in = 8'd0;
      step();
      step();
      chk_reset("reset");
      rst_n = 1'b1;
      step();
      check("idle_busy", {31'd0, bus.busy}, 32'd0);
      dir_w = '{32'h1122_3344, 32'h5566_7788};
      load(32'd2, 0, "basic");
      check("hold_addr", bus.mem_addr, BASE + 32'd4);
      check("hold_data", bus.mem_data, 32'h5566_7788);
      load(32'd0, 0, "len0");
      load(32'h0000_0401, 0, "toolong");
      load(32'd1, 1, "toggle");
      load(32'(MAXW), 0, "maxw");
      for (int k = 0; k < 8; k++) begin
         noisy = k < 2;
         load(32'($urandom_range(1, 6)), -1, "rand");
      end
      noisy = 1'b0;
      // abort a three-word load after its second write
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      send_word(32'd3, -1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         w = $urandom;
         exp_q.push_back({BASE + 32'(4 * i), w});
         send_word(w, -1, 1'b1);
      end
      step();
      rst_n = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk_reset("midrst");
      rst_n = 1'b1;
      check("midrst_pending", exp_q.size(), 32'd0);
      step();
      load(32'd3, -1, "after_rst");
`ifdef LOADER_CHECKSUM_EN
      dir_w = '{32'h0000_000F, 32'h0000_00F0};
      load(32'd2, 0, "csum_ok");
      csum_flip = 32'h0000_0001;
      dir_w = '{32'h0000_000F, 32'h0000_00F0};
      load(32'd2, 0, "csum_bad");
      csum_flip = 32'd0;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of the first memory word written.
REQ-002 SHALL have parameter MAX_WORDS, default 1024: largest accepted program length in words.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 SHALL have port byte_in  input  8  serial program byte.
REQ-007 SHALL have port byte_valid  input  1  byte_in holds a valid byte.
REQ-008 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port mem_addr  output  32  byte address to the data memory.
REQ-010 SHALL have port mem_data  output  32  word to the data memory.
REQ-011 SHALL have port mem_we  output  1  data memory write enable.
REQ-012 SHALL have port cpu_run  output  1  program loaded; CPU may fetch.
REQ-013 SHALL have port busy  output  1  load in progress.
REQ-014 SHALL have port error  output  1  load failed.
REQ-015 SHALL have port words_loaded  output  16  count of words written this load.

Function
REQ-016 Byte transfer SHALL occur only on a cycle with byte_valid=1 and byte_ready=1.
REQ-017 Bytes SHALL assemble little-endian: first accepted byte -> bits 7:0, fourth -> bits 31:24.
REQ-018 States SHALL be IDLE, LEN, DATA, WRITE, CSUM (only with macro), DONE, ERROR.
REQ-019 byte_ready SHALL be 1 only in LEN, DATA and CSUM; 0 in all other states.
REQ-020 busy SHALL be 1 in LEN, DATA, WRITE, CSUM; cpu_run 1 only in DONE; error 1 only in ERROR.
REQ-021 IDLE, DONE, ERROR: start=1 SHALL go to LEN next cycle, clear words_loaded and byte index; start ignored in other states.
REQ-022 LEN: after the 4th byte, length N latched; N=0 -> DONE; N>MAX_WORDS -> ERROR; else -> DATA.
REQ-023 DATA: after the 4th byte -> WRITE the next cycle.
REQ-024 WRITE SHALL last exactly one cycle: mem_we=1, mem_addr=BASE_ADDR+4*words_loaded, mem_data=assembled word; words_loaded increments at end of cycle.
REQ-025 From WRITE: if incremented count equals N -> DONE (or CSUM with macro), else -> DATA.
REQ-026 mem_we SHALL be 0 in every state other than WRITE; mem_addr/mem_data hold last values outside WRITE.
REQ-027 Latency: mem_we asserts the cycle immediately after the 4th byte handshake of each data word.
REQ-028 Address arithmetic SHALL be 32-bit modulo 2^32; wrap-around is not flagged.
REQ-029 Byte assembly index SHALL reset to 0 on each state entry to LEN, DATA, CSUM.
REQ-030 Gaps in byte_valid SHALL stall the loader without losing assembled bytes.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force IDLE and byte index 0, words_loaded 0, mem_we 0, byte_ready 0, busy 0, cpu_run 0, error 0, mem_addr 0, mem_data 0, checksum 0.
REQ-032 Reset mid-load SHALL abort without clearing memory words already written; rst_n has priority over start.

Configuration
REQ-033 Macro LOADER_CHECKSUM_EN defined: running XOR of all data words kept; after last WRITE go to CSUM, take 4-byte trailer; equal -> DONE, unequal -> ERROR; N=0 also goes to CSUM with expected value 0.
REQ-034 LOADER_CHECKSUM_EN undefined: no CSUM state or XOR register; last WRITE -> DONE; ERROR reachable only via REQ-022.

Verification
REQ-035 Reset, start, bytes 02 00 00 00, 44 33 22 11, 88 77 66 55 back-to-back -> writes 0x11223344@0x0, 0x55667788@0x4, then cpu_run=1, words_loaded=2.
REQ-036 Length 00 00 00 00 -> DONE next cycle, no mem_we, cpu_run=1.
REQ-037 Length 0x0401 with MAX_WORDS=1024 -> error=1, no mem_we, byte_ready=0; start again -> LEN, error=0.
REQ-038 N=1 with byte_valid toggling every other cycle -> single write of correct word, byte_ready 0 during WRITE cycle.
REQ-039 rst_n=0 after 2 of 3 words written -> all outputs at reset values next cycle; new load succeeds.
REQ-040 With LOADER_CHECKSUM_EN, words 0x0000000F, 0x000000F0, trailer 0x000000FF -> DONE; trailer 0x000000FE -> error=1, cpu_run=0.
